// File: rtl/sm_clk_pkg.sv
// rtl/sm_clk_pkg.sv - shared state enum, default widths and divide clamp for sm_clk_ctrl
package sm_clk_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_SEL_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    // Largest usable half-period exponent is CNT_W-1 so that 2^d-1 fits the counter.
    function automatic int unsigned clamp_div(input int unsigned d, input int unsigned cnt_w);
        return (d > cnt_w - 1) ? cnt_w - 1 : d;
    endfunction

endpackage

// File: rtl/sm_clk_chan.sv
// rtl/sm_clk_chan.sv - one power-of-two divided clock channel with period-boundary divide update
module sm_clk_chan
    import sm_clk_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop_arm,
    input  logic [SEL_W-1:0] devide,
    output logic             clk_out,
    output logic             tick,
    output logic             stopped
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic [SEL_W-1:0] d_cur;
    logic [SEL_W-1:0] d_next;

    assign d_next = SEL_W'(clamp_div(32'(devide), 32'(CNT_W)));
    assign last   = (CNT_W'(1) << d_cur) - CNT_W'(1);

    // clk_out is the phase bit; a stop only lands on a falling edge, so no runt pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
            cnt     <= '0;
            d_cur   <= '0;
            stopped <= 1'b1;
        end else begin
            tick <= 1'b0;
            if (stopped) begin
                if (start) begin
                    clk_out <= 1'b1;
                    cnt     <= '0;
                    d_cur   <= d_next;
                    tick    <= 1'b1;
                    stopped <= 1'b0;
                end
            end else if (cnt == last) begin
                cnt <= '0;
                if (clk_out) begin
                    clk_out <= 1'b0;
                    if (stop_arm) begin
                        stopped <= 1'b1;
                    end
                end else begin
                    clk_out <= 1'b1;
                    tick    <= 1'b1;
                    d_cur   <= d_next;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sm_clk_ctrl.sv
// rtl/sm_clk_ctrl.sv - multi-channel clock divider with run/drain/step FSM (SM_CLK_CTRL_STEP_EN enables step)
module sm_clk_ctrl
    import sm_clk_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      run,
    input  logic                      step,
    input  logic [CHANNELS*SEL_W-1:0] devide,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic                      busy
);

    state_t              state;
    state_t              state_nx;
    logic [CHANNELS-1:0] stopped;
    logic [CHANNELS-1:0] start;
    logic                all_stopped;
    logic                stop_arm;
    logic                step_first;

    assign all_stopped = &stopped;
    assign stop_arm    = (state == ST_DRAIN) || (state == ST_STEP);
    assign busy        = (state != ST_IDLE);
    assign start       = stopped & {CHANNELS{(state == ST_RUN) || step_first}};

`ifdef SM_CLK_CTRL_STEP_EN
    // Marks the first STEP cycle: channels start here, and IDLE must not be re-entered yet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_first <= 1'b0;
        end else begin
            step_first <= (state == ST_IDLE) && (state_nx == ST_STEP);
        end
    end
`else
    logic step_unused;
    assign step_first  = 1'b0;
    assign step_unused = step;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nx = ST_RUN;
                end
`ifdef SM_CLK_CTRL_STEP_EN
                else if (step) begin
                    state_nx = ST_STEP;
                end
`endif
            end
            ST_RUN: begin
                if (!run) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (run) begin
                    state_nx = ST_RUN;
                end else if (all_stopped) begin
                    state_nx = ST_IDLE;
                end
            end
`ifdef SM_CLK_CTRL_STEP_EN
            ST_STEP: begin
                if (all_stopped && !step_first) begin
                    state_nx = ST_IDLE;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        sm_clk_chan #(
            .CNT_W(CNT_W),
            .SEL_W(SEL_W)
        ) u_chan (
            .clk     (clk),
            .rstn    (rstn),
            .start   (start[i]),
            .stop_arm(stop_arm),
            .devide  (devide[i*SEL_W +: SEL_W]),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .stopped (stopped[i])
        );
    end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// tb/tb_sm_clk_ctrl.sv - directed self-checking bench for sm_clk_ctrl (CNT_W=16, two channels)
module tb_sm_clk_ctrl;

    localparam int CH = 2;
    localparam int CW = 16;
    localparam int SW = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic [CH*SW-1:0] devide = '0;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    // {tick[1:0], clk_out[1:0]} for edges N+1..N+10, ch0 d=0, ch1 d=2
    logic [3:0] exp_a [10] = '{4'b1111, 4'b0010, 4'b0111, 4'b0010, 4'b0101,
                              4'b0000, 4'b0101, 4'b0000, 4'b1111, 4'b0010};
    // {tick[1], clk_out[1]} for edges N+11..N+22 after ch1 divide 2 -> 1
    logic [1:0] exp_b [12] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01};
    // {busy, tick[1:0], clk_out[1:0]} for edges N+1..N+12, run dropped before N+5
    logic [4:0] exp_c [12] = '{5'b11111, 5'b10011, 5'b10010, 5'b10010, 5'b10111, 5'b10011,
                              5'b10010, 5'b10010, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
`ifdef SM_CLK_CTRL_STEP_EN
    // {busy, tick, clk_out} from the step sample edge, ch0 d=2, ch1 d=0
    logic [4:0] exp_d [9] = '{5'b10000, 5'b11111, 5'b10001, 5'b10001, 5'b10001,
                             5'b10000, 5'b00000, 5'b00000, 5'b00000};
`else
    logic [4:0] exp_d [9] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                             5'b00000, 5'b00000, 5'b00000, 5'b00000};
`endif

    always #5 clk = ~clk;

    sm_clk_ctrl #(
        .CHANNELS(CH),
        .CNT_W   (CW),
        .SEL_W   (SW)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .run    (run),
        .step   (step),
        .devide (devide),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        run  = 1'b0;
        step = 1'b0;
        cyc();
        cyc();
        chk("reset_state", 32'({busy, tick, clk_out}), 32'h0);
        rstn = 1'b1;
        cyc();
    endtask

    initial begin
        do_reset();

        devide = {5'd2, 5'd0};
        run = 1'b1;
        cyc();
        chk("a_edge_n", 32'({busy, tick, clk_out}), 32'h10);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("a_k%0d", k), 32'({tick, clk_out}), 32'(exp_a[k-1]));
        end

        devide = {5'd1, 5'd0};
        for (int k = 11; k <= 22; k++) begin
            cyc();
            chk($sformatf("b_k%0d", k), 32'({tick[1], clk_out[1]}), 32'(exp_b[k-11]));
        end

        do_reset();
        devide = {5'd3, 5'd1};
        run = 1'b1;
        cyc();
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("c_k%0d", k), 32'({busy, tick, clk_out}), 32'(exp_c[k-1]));
            if (k == 4) run = 1'b0;
        end

        do_reset();
        devide = {5'd0, 5'd2};
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("d_k0", 32'({busy, tick, clk_out}), 32'(exp_d[0]));
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("d_k%0d", k), 32'({busy, tick, clk_out}), 32'(exp_d[k]));
            step = (k == 2);
        end

        do_reset();
        devide = {5'd0, 5'd31};
        run = 1'b1;
        cyc();
        cyc();
        n = 0;
        while (clk_out[0] && n < 40000) begin
            n++;
            cyc();
        end
        chk("clamp_high_len", 32'(n), 32'd32768);

        do_reset();
        devide = {5'd2, 5'd0};
        run = 1'b1;
        cyc();
        cyc();
        chk("f_pre_reset", 32'({busy, tick, clk_out}), 32'h1f);
        #2 rstn = 1'b0;
        #1 chk("f_async_reset", 32'({busy, tick, clk_out}), 32'h0);
        run = 1'b0;
        cyc();
        cyc();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("f_quiet_%0d", k), 32'({busy, tick, clk_out}), 32'h0);
        end
        run = 1'b1;
        cyc();
        chk("f_restart_n", 32'({busy, tick, clk_out}), 32'h10);
        cyc();
        chk("f_restart_n1", 32'({busy, tick, clk_out}), 32'h1f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sm_clk_ctrl.md
# sm_clk_ctrl

Parametrised multi-channel successor to the single-output CPU clock divider. It generates CHANNELS independent power-of-two-divided clock outputs, each with a one-cycle tick strobe. Divide changes are glitch-free and take effect only at period boundaries. Run, orderly stop and single-step control are provided. It sits between the board clock and the CPU/peripheral clock domains in the top level and replaces the raw counter-bit tap.

## Interface
- CHANNELS, 2, number of independent output channels
- CNT_W, 32, per-channel half-period counter width
- SEL_W, 5, width of each channel's divide selector
- clk  in  1  board clock
- rstn  in  1  reset; asynchronous, active-low
- run  in  1  level; 1 = channels run continuously
- step  in  1  one-cycle pulse; requests exactly one full period on every channel (only honoured while idle)
- devide  in  CHANNELS*SEL_W  channel i selector at bits [i*SEL_W +: SEL_W]; half-period = 2^d cycles
- clk_out  out  CHANNELS  divided clocks, registered
- tick  out  CHANNELS  one-cycle pulse coincident with each clk_out rising edge
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, STEP.
  - IDLE→RUN when run=1.
  - IDLE→STEP when run=0 and step=1.
  - RUN→DRAIN when run=0.
  - DRAIN→RUN when run=1 again before all channels have stopped. Stopped channels restart via the start sequence.
  - DRAIN→IDLE and STEP→IDLE when all channels are stopped.
  - STEP ignores run until it returns to IDLE.
  - step is ignored outside IDLE.
- Each channel holds a phase bit, a CNT_W counter, a latched divide d_cur, and a stopped flag.
- Start, on the first active cycle:
  - phase←1, cnt←0, d_cur←clamp(devide_i), tick←1, stopped←0.
- Active operation:
  - cnt increments each cycle.
  - When cnt = 2^d_cur−1: cnt←0 and phase toggles.
  - On a 0→1 toggle: tick←1 and d_cur←clamp(devide_i). This is the only point where the divide updates.
- Stop (DRAIN or STEP): when a channel's phase falls 1→0, it sets stopped and holds phase=0, cnt=0. No further rising edge occurs, so no runt pulses are ever produced.
- In STEP the stop condition is armed from the start cycle, so each channel emits exactly one full period of 2^(d+1) cycles.
- clamp(d) = min(d, CNT_W−1).
- Channels are independent. Slow channels keep running during DRAIN until their own falling edge.

## Timing
- Reset values: clk_out=0, tick=0, busy=0, state=IDLE, all counters 0, d_cur=0, stopped=1.
- run sampled high at edge N → state=RUN at N; clk_out=1 and tick=1 at edge N+1.
- For divide d: clk_out is high for 2^d cycles, then low for 2^d cycles. d=0 gives clk/2.
- A devide change becomes visible at the next rising edge of clk_out, never mid-period.
- After the last channel's falling edge, busy drops one cycle later.
- Simultaneous run=1 and step=1 in IDLE: run wins.
- Asserting rstn low mid-period forces all outputs low immediately (asynchronous).

## Configuration
- SM_CLK_CTRL_STEP_EN defined: STEP state and step input are functional.
- Not defined: STEP state is removed from the FSM, the step port remains but is ignored, and only run/drain behaviour exists.

## Structure
- Shared package sm_clk_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, STEP)
  - the clamp function
  - the default CNT_W/SEL_W constants
- Sub-module sm_clk_chan implements one channel with start, stop_arm and devide inputs and clk_out, tick and stopped outputs. It is instantiated CHANNELS times under a generate loop.
- The top-level FSM is in sm_clk_ctrl.

## Test plan
- Reset then run=1, devide ch0=0, ch1=2 → ch0 toggles every cycle and ch1 every 4 cycles. First tick on both at edge N+1 after run is sampled.
- Change ch1 devide from 2 to 1 mid-high-phase → current period completes as 4 high + 4 low, then the next period is 2 high + 2 low. No runt.
- run=1 with ch0=1, ch1=3, then run=0 in the middle of ch1's high phase → ch0 stops after its next falling edge. ch1 completes its 8-cycle high phase and falls. busy drops 1 cycle after ch1 falls. No further ticks.
- step pulse in IDLE with ch0=2 → exactly one tick and a clk_out period of 4 high + 4 low, then busy=0. A second step while busy is ignored.
- devide=31 with CNT_W=16 → d clamped to 15, giving a half-period of 32768 cycles.
- rstn asserted mid-RUN → clk_out, tick and busy are 0 immediately. After release, nothing toggles until run is sampled high.
